// File: rtl/muldiv_ctrl_pkg.sv
//------------------------------------------------------------------------------
// muldiv_ctrl_pkg : shared encodings for the EX-stage multiply/divide control
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package muldiv_ctrl_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_ctrl_hilo_reg.sv
//------------------------------------------------------------------------------
// hilo_reg : architectural HI/LO register pair with independent write enables
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hilo_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              hi_we,
    input  logic [DATA_W-1:0] hi_d,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] lo_d,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (hi_we) hi <= hi_d;
            if (lo_we) lo <= lo_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
//------------------------------------------------------------------------------
// muldiv_ctrl : sequences the EX-stage multiplier/divider and owns HI/LO
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                op_valid,
    input  logic [2:0]          op_type,
    input  logic [DATA_W-1:0]   src_a,
    input  logic [DATA_W-1:0]   src_b,
    input  logic                flush,
    output logic                ex_stall,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo,
    output logic                mul_en,
    output logic                mul_signed,
    output logic [DATA_W-1:0]   mul_x,
    output logic [DATA_W-1:0]   mul_y,
    input  logic [2*DATA_W-1:0] mul_result,
    input  logic                mul_complete,
    output logic                div_start,
    output logic                div_signed,
    output logic [DATA_W-1:0]   div_x,
    output logic [DATA_W-1:0]   div_y,
    output logic                div_cancel,
    input  logic                div_done,
    input  logic [DATA_W-1:0]   div_quot,
    input  logic [DATA_W-1:0]   div_rem
);

    localparam logic [2:0] c_CNT_LAST = 3'(MUL_LAT - 1);

    state_e              r_state;
    logic [2:0]          r_cnt;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic                r_signed;
    logic                r_div_first;

    logic                w_is_mul;
    logic                w_is_div;
    logic                w_accept;
    logic                w_mul_wr;
    logic                w_div_wr;
    logic                w_hi_we;
    logic                w_lo_we;
    logic [DATA_W-1:0]   w_hi_d;
    logic [DATA_W-1:0]   w_lo_d;

    assign w_is_mul = (op_type == OP_MULT) || (op_type == OP_MULTU);
    assign w_is_div = (op_type == OP_DIV)  || (op_type == OP_DIVU);
    assign w_accept = (r_state == ST_IDLE) && op_valid && !flush;

    // Flush always wins over a completion landing in the same cycle.
    assign w_mul_wr = (r_state == ST_MUL) && !flush && (r_cnt == c_CNT_LAST) && mul_complete;
    assign w_div_wr = (r_state == ST_DIV) && !flush && div_done;

    always_comb begin
        ex_stall = 1'b0;
        if (!flush) begin
            case (r_state)
                ST_IDLE: ex_stall = op_valid && (w_is_mul || w_is_div);
                ST_MUL:  ex_stall = !w_mul_wr;
                ST_DIV:  ex_stall = !w_div_wr;
                default: ex_stall = 1'b0;
            endcase
        end
    end

    assign mul_en     = (r_state == ST_MUL);
    assign mul_signed = r_signed;
    assign mul_x      = r_op_a;
    assign mul_y      = r_op_b;
    assign div_start  = (r_state == ST_DIV) && r_div_first;
    assign div_signed = r_signed;
    assign div_x      = r_op_a;
    assign div_y      = r_op_b;
    assign div_cancel = (r_state == ST_DIV) && flush;

    always_comb begin
        w_hi_we = 1'b0;
        w_lo_we = 1'b0;
        w_hi_d  = src_a;
        w_lo_d  = src_a;
        if (w_accept && (op_type == OP_MTHI)) begin
            w_hi_we = 1'b1;
        end else if (w_accept && (op_type == OP_MTLO)) begin
            w_lo_we = 1'b1;
        end else if (w_mul_wr) begin
            w_hi_we = 1'b1;
            w_lo_we = 1'b1;
            w_hi_d  = mul_result[2*DATA_W-1:DATA_W];
            w_lo_d  = mul_result[DATA_W-1:0];
        end else if (w_div_wr) begin
            w_hi_we = 1'b1;
            w_lo_we = 1'b1;
            w_hi_d  = div_rem;
            w_lo_d  = div_quot;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_signed    <= 1'b0;
            r_div_first <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        r_op_a   <= src_a;
                        r_op_b   <= src_b;
                        r_signed <= (op_type == OP_MULT);
                        r_cnt    <= '0;
                        r_state  <= ST_MUL;
                    end else if (w_accept && w_is_div) begin
                        r_op_a      <= src_a;
                        r_op_b      <= src_b;
                        r_signed    <= (op_type == OP_DIV);
                        r_div_first <= 1'b1;
                        r_state     <= ST_DIV;
                    end
                end
                ST_MUL: begin
                    // A late multiplier parks the counter on its last value.
                    if (flush || w_mul_wr) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt != c_CNT_LAST) begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_DIV: begin
                    r_div_first <= 1'b0;
                    if (flush || w_div_wr) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo_reg (
        .clk    (clk),
        .resetn (resetn),
        .hi_we  (w_hi_we),
        .hi_d   (w_hi_d),
        .lo_we  (w_lo_we),
        .lo_d   (w_lo_d),
        .hi     (hi),
        .lo     (lo)
    );

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
//------------------------------------------------------------------------------
// tb_muldiv_ctrl : directed, table-driven bench for muldiv_ctrl
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int W = 32;

    logic          clk;
    logic          resetn;
    logic          op_valid;
    logic [2:0]    op_type;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic          flush;
    logic          ex_stall;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          mul_en;
    logic          mul_signed;
    logic [W-1:0]  mul_x;
    logic [W-1:0]  mul_y;
    logic [2*W-1:0] mul_result;
    logic          mul_complete;
    logic          div_start;
    logic          div_signed;
    logic [W-1:0]  div_x;
    logic [W-1:0]  div_y;
    logic          div_cancel;
    logic          div_done;
    logic [W-1:0]  div_quot;
    logic [W-1:0]  div_rem;

    int n_checks = 0;
    int n_errors = 0;
    int div_starts = 0;
    logic          mul_hold;
    logic [7:0]    en_cnt;

    muldiv_ctrl #(.MUL_LAT(2), .DATA_W(W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .op_valid     (op_valid),
        .op_type      (op_type),
        .src_a        (src_a),
        .src_b        (src_b),
        .flush        (flush),
        .ex_stall     (ex_stall),
        .hi           (hi),
        .lo           (lo),
        .mul_en       (mul_en),
        .mul_signed   (mul_signed),
        .mul_x        (mul_x),
        .mul_y        (mul_y),
        .mul_result   (mul_result),
        .mul_complete (mul_complete),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .div_x        (div_x),
        .div_y        (div_y),
        .div_cancel   (div_cancel),
        .div_done     (div_done),
        .div_quot     (div_quot),
        .div_rem      (div_rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural two-cycle multiplier; mul_hold delays completion.
    logic signed [2*W-1:0] s_prod;
    logic        [2*W-1:0] u_prod;
    assign s_prod = $signed({{W{mul_x[W-1]}}, mul_x}) * $signed({{W{mul_y[W-1]}}, mul_y});
    assign u_prod = {{W{1'b0}}, mul_x} * {{W{1'b0}}, mul_y};
    assign mul_result   = mul_signed ? s_prod : u_prod;
    assign mul_complete = mul_en && (en_cnt >= 8'd1) && !mul_hold;

    always @(posedge clk) begin
        if (!mul_en) en_cnt <= 8'd0;
        else if (en_cnt != 8'hFF) en_cnt <= en_cnt + 8'd1;
        if (div_start) div_starts <= div_starts + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    task automatic run_mul(input vec_t v);
        @(negedge clk);
        op_valid = 1'b1; op_type = v.op; src_a = v.a; src_b = v.b;
        #1;
        check("mul_accept_stall", 64'(ex_stall), 64'd1);
        check("mul_accept_en", 64'(mul_en), 64'd0);
        @(negedge clk); #1;
        check("mul_t1_en", 64'(mul_en), 64'd1);
        check("mul_t1_stall", 64'(ex_stall), 64'd1);
        check("mul_t1_x", 64'(mul_x), 64'(v.a));
        check("mul_t1_y", 64'(mul_y), 64'(v.b));
        check("mul_t1_signed", 64'(mul_signed), 64'(v.op == OP_MULT));
        @(negedge clk); #1;
        check("mul_t2_en", 64'(mul_en), 64'd1);
        check("mul_t2_stall", 64'(ex_stall), 64'd0);
        check("mul_t2_x", 64'(mul_x), 64'(v.a));
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        check("mul_done_en", 64'(mul_en), 64'd0);
        check("mul_done_stall", 64'(ex_stall), 64'd0);
        check("mul_hi", 64'(hi), 64'(v.exp_hi));
        check("mul_lo", 64'(lo), 64'(v.exp_lo));
    endtask

    vec_t vecs[5];
    int   s0;

    initial begin
        vecs[0] = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{OP_MULT,  32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000};
        vecs[3] = '{OP_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
        vecs[4] = '{OP_MULT,  32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        resetn = 1'b0; op_valid = 1'b0; op_type = 3'd0; src_a = '0; src_b = '0;
        flush = 1'b0; div_done = 1'b0; div_quot = '0; div_rem = '0; mul_hold = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_stall", 64'(ex_stall), 64'd0);
        check("rst_mul_en", 64'(mul_en), 64'd0);
        check("rst_div_start", 64'(div_start), 64'd0);
        check("rst_div_cancel", 64'(div_cancel), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 5; i++) run_mul(vecs[i]);

        // MTHI then MTLO back-to-back, then MTLO masked by flush
        @(negedge clk);
        op_valid = 1'b1; op_type = OP_MTHI; src_a = 32'h12345678;
        #1; check("mthi_stall", 64'(ex_stall), 64'd0);
        @(negedge clk);
        op_type = OP_MTLO; src_a = 32'h9ABCDEF0;
        #1; check("mthi_hi", 64'(hi), 64'h12345678);
        check("mtlo_stall", 64'(ex_stall), 64'd0);
        @(negedge clk);
        op_valid = 1'b0;
        #1; check("mtlo_lo", 64'(lo), 64'h9ABCDEF0);
        @(negedge clk);
        op_valid = 1'b1; op_type = OP_MTLO; src_a = 32'h11111111; flush = 1'b1;
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0;
        #1; check("mtlo_flush_lo", 64'(lo), 64'h9ABCDEF0);
        check("mtlo_flush_hi", 64'(hi), 64'h12345678);

        // Signed DIV -7/2, divider done 33 cycles after start
        @(negedge clk);
        op_valid = 1'b1; op_type = OP_DIV; src_a = 32'hFFFFFFF9; src_b = 32'd2;
        #1; check("div_accept_stall", 64'(ex_stall), 64'd1);
        check("div_accept_start", 64'(div_start), 64'd0);
        s0 = div_starts;
        @(negedge clk); #1;
        check("div_start", 64'(div_start), 64'd1);
        check("div_x", 64'(div_x), 64'hFFFFFFF9);
        check("div_y", 64'(div_y), 64'd2);
        check("div_signed", 64'(div_signed), 64'd1);
        begin
            int low_stall = 0;
            for (int i = 0; i < 31; i++) begin
                @(negedge clk); #1;
                if (!ex_stall || div_start) low_stall++;
            end
            check("div_wait_stall", 64'(low_stall), 64'd0);
        end
        @(negedge clk);
        div_done = 1'b1; div_quot = 32'hFFFFFFFD; div_rem = 32'hFFFFFFFF;
        #1; check("div_done_stall", 64'(ex_stall), 64'd0);
        @(negedge clk);
        div_done = 1'b0; op_valid = 1'b0;
        #1; check("div_hi", 64'(hi), 64'hFFFFFFFF);
        check("div_lo", 64'(lo), 64'hFFFFFFFD);
        check("div_start_count", 64'(div_starts - s0), 64'd1);

        // DIVU flushed mid-operation
        @(negedge clk);
        op_valid = 1'b1; op_type = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk); #1;
        check("divu_signed", 64'(div_signed), 64'd0);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        #1; check("flush_mid_cancel", 64'(div_cancel), 64'd1);
        check("flush_mid_stall", 64'(ex_stall), 64'd0);
        @(negedge clk);
        flush = 1'b0; op_valid = 1'b0;
        #1; check("flush_mid_idle", 64'(ex_stall), 64'd0);
        check("flush_mid_cancel_off", 64'(div_cancel), 64'd0);
        check("flush_mid_hi", 64'(hi), 64'hFFFFFFFF);
        check("flush_mid_lo", 64'(lo), 64'hFFFFFFFD);

        // Flush coincident with div_done
        @(negedge clk);
        op_valid = 1'b1; op_type = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
        repeat (3) @(negedge clk);
        div_done = 1'b1; div_quot = 32'd14; div_rem = 32'd2; flush = 1'b1;
        #1; check("flush_done_cancel", 64'(div_cancel), 64'd1);
        check("flush_done_stall", 64'(ex_stall), 64'd0);
        @(negedge clk);
        div_done = 1'b0; flush = 1'b0; op_valid = 1'b0;
        #1; check("flush_done_idle", 64'(ex_stall), 64'd0);
        check("flush_done_hi", 64'(hi), 64'hFFFFFFFF);
        check("flush_done_lo", 64'(lo), 64'hFFFFFFFD);

        // Stray div_done while idle
        @(negedge clk);
        div_done = 1'b1; div_quot = 32'hAAAA0000; div_rem = 32'h0000AAAA;
        @(negedge clk);
        div_done = 1'b0;
        #1; check("stray_done_hi", 64'(hi), 64'hFFFFFFFF);
        check("stray_done_lo", 64'(lo), 64'hFFFFFFFD);

        // Late multiplier completion holds the stall
        mul_hold = 1'b1;
        @(negedge clk);
        op_valid = 1'b1; op_type = OP_MULTU; src_a = 32'd6; src_b = 32'd7;
        begin
            int low_stall = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk); #1;
                if (!ex_stall || !mul_en) low_stall++;
            end
            check("mul_hold_stall", 64'(low_stall), 64'd0);
        end
        mul_hold = 1'b0;
        #1; check("mul_release_stall", 64'(ex_stall), 64'd0);
        @(negedge clk);
        op_valid = 1'b0;
        #1; check("mul_hold_hi", 64'(hi), 64'd0);
        check("mul_hold_lo", 64'(lo), 64'd42);

        // Asynchronous reset during MUL at cnt=1
        @(negedge clk);
        op_valid = 1'b1; op_type = OP_MTHI; src_a = 32'hDEADBEEF;
        @(negedge clk);
        mul_hold = 1'b1; op_type = OP_MULT; src_a = 32'd7; src_b = 32'd9;
        repeat (2) @(negedge clk);
        #1; check("pre_rst_stall", 64'(ex_stall), 64'd1);
        check("pre_rst_hi", 64'(hi), 64'hDEADBEEF);
        resetn = 1'b0; op_valid = 1'b0;
        #1; check("arst_mul_en", 64'(mul_en), 64'd0);
        check("arst_stall", 64'(ex_stall), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_mul_x", 64'(mul_x), 64'd0);
        @(negedge clk);
        resetn = 1'b1; mul_hold = 1'b0;
        run_mul('{OP_MULT, 32'd3, 32'd5, 32'd0, 32'd15});

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequences the EX-stage multiply/divide resources of the five-stage pipeline and owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and drives the fixed-latency pipelined multiplier and the variable-latency divider.
- Stalls EX until the result is written and aborts cleanly on pipeline flush.

Parameters:
- MUL_LAT, 2: cycles the multiplier enable is held; complete is sampled in the last cycle; legal range 1..7.
- DATA_W, 32: operand width; HI/LO are DATA_W each.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- op_valid  in  1  EX holds a HI/LO-class instruction
- op_type  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 are no-op
- src_a  in  DATA_W  rs value
- src_b  in  DATA_W  rt value
- flush  in  1  exception/eret flush of EX
- ex_stall  out  1  hold EX and earlier stages
- hi  out  DATA_W  architectural HI
- lo  out  DATA_W  architectural LO
- mul_en  out  1  to multiplier enable (mul)
- mul_signed  out  1  to multiplier
- mul_x, mul_y  out  DATA_W  multiplier operands
- mul_result  in  2*DATA_W  multiplier product
- mul_complete  in  1  multiplier complete
- div_start  out  1  one-cycle start pulse
- div_signed  out  1  to divider
- div_x, div_y  out  DATA_W  dividend, divisor
- div_cancel  out  1  one-cycle abort pulse
- div_done  in  1  quotient/remainder valid, single-cycle pulse
- div_quot, div_rem  in  DATA_W  divider results

Behaviour:
- Reset (async, any state): state=IDLE, hi=lo=0, operand regs=0, cnt=0, all outputs 0.
- States: IDLE, MUL, DIV.
- IDLE, op_valid & !flush:
  - MULT/MULTU: latch src_a/src_b and signedness; cnt=0; go MUL.
  - DIV/DIVU: latch operands; go DIV.
  - MTHI/MTLO: write hi/lo from src_a at the clock edge; no stall; stay IDLE.
- ex_stall (combinational):
  - Asserted in IDLE on the accept cycle of MULT/MULTU/DIV/DIVU.
  - Asserted in MUL/DIV except the write cycle.
  - Deasserted whenever flush=1.
- MUL:
  - mul_en=1 and mul_x/mul_y/mul_signed driven from latched regs every MUL cycle; cnt increments.
  - Write cycle: cnt==MUL_LAT-1 and mul_complete=1. Then {hi,lo}<=mul_result, ex_stall=0, next IDLE.
  - MUL_LAT=2 gives EX occupancy T (accept), T+1, T+2 (write); operands are stable for the whole enable window.
  - If cnt reaches MUL_LAT-1 without mul_complete: hold the state and stall until complete arrives.
- DIV:
  - div_start=1 in the first DIV cycle only.
  - Wait for div_done. Write cycle: hi<=div_rem, lo<=div_quot, ex_stall=0, next IDLE.
  - Divide-by-zero: write whatever the divider returns; no trap.
- Flush:
  - Has priority over completion in the same cycle: no HI/LO write, next IDLE.
  - In DIV, pulse div_cancel=1 for that cycle.
  - A flush in IDLE suppresses accept, including MTHI/MTLO.
- New ops are accepted only in IDLE. The stall guarantees op_valid is the same held instruction while busy, so new ops are never seen then.
- div_done outside DIV is ignored. mul_complete outside MUL is ignored.
- hi/lo are register outputs only. No internal bypass: a write is visible the cycle after the write edge. The forwarding unit owns MFHI/MFLO hazards.

Decomposition:
- Shared package:
  - op_type encodings (OP_MULT..OP_MTLO)
  - state encodings
  - DATA_W default
- One natural sub-module, hilo_reg: the HI/LO register pair with async reset and independent write enables, fed by this FSM.

Test Plan:
- MULT src_a=0xFFFFFFFF, src_b=0x00000002 -> mul_en high T+1..T+2, stall high T..T+1, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE, same cycle timing.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2, divider done after 33 cycles -> one div_start pulse; stall until div_done; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV in flight, flush asserted mid-operation and again in the div_done cycle -> div_cancel pulse each time, hi/lo unchanged, IDLE next cycle, stall low.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 back-to-back -> no stall; hi/lo updated one cycle after each op; flush concurrent with MTLO leaves lo unchanged.
- resetn low asynchronously during MUL at cnt=1 -> all outputs 0 immediately, hi=lo=0; after release, a MULT 3*5 gives hi=0, lo=15.
